control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) plus per-class execute steps, with HALT and sticky illegal flag.
// Optional build macro CTRL_MEM_WAIT_EN stretches T1 until mem_rdy.
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        PCout,
  output logic        incPC,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [4:0]  opcode,
  output logic        instr_done,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
  } state_e;

  state_e      state_q;
  state_e      after_done;
  logic [4:0]  op;
  logic        is_alu, is_muldiv, is_nop, is_halt, is_illegal;
  logic        t1_advance;
  logic [15:0] ra_hot, rb_hot, rc_hot;
  logic        unused_bits;

  assign op         = ir[31:27];
  assign is_alu     = (op <= 5'd10);
  assign is_muldiv  = (op == 5'd15) || (op == 5'd16);
  assign is_nop     = (op == 5'd25);
  assign is_halt    = (op == 5'd26);
  assign is_illegal = !(is_alu || is_muldiv || is_nop || is_halt);
  assign ra_hot     = 16'h0001 << ir[26:23];
  assign rb_hot     = 16'h0001 << ir[22:19];
  assign rc_hot     = 16'h0001 << ir[18:15];
  assign after_done = run ? StT0 : StIdle;

`ifdef CTRL_MEM_WAIT_EN
  assign t1_advance  = mem_rdy;
  assign unused_bits = ^ir[14:0];
`else
  assign t1_advance  = 1'b1;
  assign unused_bits = ^{ir[14:0], mem_rdy};
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      illegal <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (run) state_q <= StT0;
        StT0:   state_q <= StT1;
        StT1:   if (t1_advance) state_q <= StT2;
        StT2:   state_q <= StT3;
        StT3: begin
          if (is_alu || is_muldiv) state_q <= StT4;
          else if (is_halt)        state_q <= StHalt;
          else                     state_q <= after_done;
          // Unrecognised opcodes retire like NOP but leave a sticky mark.
          if (is_illegal) illegal <= 1'b1;
        end
        StT4:   state_q <= StT5;
        StT5:   state_q <= is_muldiv ? StT6 : after_done;
        StT6:   state_q <= after_done;
        StHalt: state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    PCout      = 1'b0;
    incPC      = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    ZLowOut    = 1'b0;
    ZHighOut   = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    Rout       = 16'h0000;
    Rin        = 16'h0000;
    opcode     = 5'd0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_q)
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        incPC = 1'b1;
        Zin   = 1'b1;
      end
      StT1: begin
        ZLowOut = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        if (is_alu || is_muldiv) begin
          Rout = rb_hot;
          Yin  = 1'b1;
        end else begin
          instr_done = 1'b1;
        end
      end
      StT4: begin
        Rout   = rc_hot;
        opcode = op;
        Zin    = 1'b1;
      end
      StT5: begin
        ZLowOut = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Rin        = ra_hot;
          instr_done = 1'b1;
        end
      end
      StT6: begin
        ZHighOut   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      StHalt: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
